// File: rtl/memwrite_checker.sv
// Data-memory write-port checker: compares core writes against a programmable (addr, data) table.
// Define MEMWRITE_CHECKER_UNORDERED_EN to let expected entries match in any order.
module memwrite_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_count,
  input  logic [ADDR_W-1:0] scratch_lo,
  input  logic [ADDR_W-1:0] scratch_hi,
  input  logic [CNT_W-1:0]  timeout_limit,
  input  logic              start,
  input  logic              clear,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [IDX_W:0]    match_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [ADDR_W-1:0] tbl_addr [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [IDX_W:0]    match_q, match_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic wr_match, wr_addr_eq, completing, in_scratch, timeout_hit;
  logic [CNT_W-1:0] lim_m1;

  // Table has no reset and survives clear.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cfg_we && !clear) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

`ifdef MEMWRITE_CHECKER_UNORDERED_EN
  logic [DEPTH-1:0] hit_q, hit_d;
  logic [IDX_W-1:0] hit_idx;

  always_comb begin
    wr_match   = 1'b0;
    wr_addr_eq = 1'b0;
    hit_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((IDX_W+1)'(i) < count_q && !hit_q[IDX_W'(i)] && dataadr == tbl_addr[IDX_W'(i)]) begin
        wr_addr_eq = 1'b1;
        if (writedata == tbl_data[IDX_W'(i)] && !wr_match) begin
          wr_match = 1'b1;
          hit_idx  = IDX_W'(i);
        end
      end
    end
  end
`else
  always_comb begin
    wr_addr_eq = (dataadr == tbl_addr[match_q[IDX_W-1:0]]);
    wr_match   = wr_addr_eq && (writedata == tbl_data[match_q[IDX_W-1:0]]);
  end
`endif

  always_comb begin
    in_scratch  = (dataadr >= scratch_lo) && (dataadr <= scratch_hi);
    lim_m1      = timeout_limit - CNT_W'(1);
    timeout_hit = (timeout_limit != '0) && (cyc_q == lim_m1);
    completing  = ((match_q + (IDX_W+1)'(1)) == count_q);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    match_d = match_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
    hit_d   = hit_q;
`endif
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      match_d = '0;
      cyc_d   = '0;
      code_d  = '0;
      faddr_d = '0;
      fdata_d = '0;
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
      hit_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_d = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
            match_d = '0;
            cyc_d   = '0;
            code_d  = '0;
            faddr_d = '0;
            fdata_d = '0;
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
            hit_d   = '0;
`endif
            state_d = (cfg_count == '0) ? S_PASS : S_ARMED;
          end
        end
        S_ARMED: begin
          cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
          // A completing match beats a timeout on the same edge.
          if (memwrite && wr_match) begin
            match_d = match_q + (IDX_W+1)'(1);
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
            hit_d[hit_idx] = 1'b1;
`endif
            if (completing) begin
              state_d = S_PASS;
            end else if (timeout_hit) begin
              state_d = S_FAIL;
              code_d  = 2'd3;
              faddr_d = '0;
              fdata_d = '0;
            end
          end else if (memwrite && wr_addr_eq) begin
            state_d = S_FAIL;
            code_d  = 2'd1;
            faddr_d = dataadr;
            fdata_d = writedata;
          end else if (memwrite && !in_scratch) begin
            state_d = S_FAIL;
            code_d  = 2'd2;
            faddr_d = dataadr;
            fdata_d = writedata;
          end else if (timeout_hit) begin
            state_d = S_FAIL;
            code_d  = 2'd3;
            faddr_d = '0;
            fdata_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      match_q <= '0;
      cyc_q   <= '0;
      code_q  <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
      hit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
      hit_q   <= hit_d;
`endif
    end
  end

  assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass        = (state_q == S_PASS);
  assign fail_code   = code_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;
  assign match_count = match_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// Scoreboard bench for memwrite_checker: expected results queued at stimulus time, popped at result time.
module tb_memwrite_checker;

  logic        clk, reset, cfg_we, start, clear, memwrite;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, scratch_lo, scratch_hi, dataadr, writedata;
  logic [3:0]  cfg_count;
  logic [7:0]  timeout_limit;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;
  logic [3:0]  match_count;
  logic [7:0]  cycle_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        d;
    logic        p;
    logic [1:0]  code;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic [3:0]  mc;
  } res_t;

  res_t exp_q[$];
  res_t got, expv;

  memwrite_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
    .scratch_lo(scratch_lo), .scratch_hi(scratch_hi), .timeout_limit(timeout_limit),
    .start(start), .clear(clear), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_addr(fail_addr), .fail_data(fail_data), .match_count(match_count),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk(input logic d, input logic p, input logic [1:0] c,
                              input logic [31:0] a, input logic [31:0] dt, input logic [3:0] m);
    return '{d: d, p: p, code: c, faddr: a, fdata: dt, mc: m};
  endfunction

  function automatic res_t obs();
    return '{d: done, p: pass, code: fail_code, faddr: fail_addr, fdata: fail_data, mc: match_count};
  endfunction

  task automatic load(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic arm(input logic [3:0] cnt, input logic [31:0] lo, input logic [31:0] hi,
                     input logic [7:0] lim);
    cfg_count = cnt; scratch_lo = lo; scratch_hi = hi; timeout_limit = lim; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    idle(2);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL reset_outputs: got %h expected %h", got, expv); end
    tests++;
    if (cycle_count !== 8'd0) begin fails++; $display("FAIL reset_cycles: got %0d expected 0", cycle_count); end
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_in_order_pass();
    load(0, 84, 7);
    arm(1, 80, 80, 0);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 1));
    wr(80, 5); wr(80, 9); wr(84, 7);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL in_order_pass: got %h expected %h", got, expv); end
    do_clear();
  endtask

  task automatic test_data_mismatch();
    load(0, 84, 7);
    arm(1, 80, 80, 0);
    exp_q.push_back(mk(1, 0, 1, 84, 6, 0));
    wr(80, 5); wr(84, 6);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL data_mismatch: got %h expected %h", got, expv); end
    do_clear();
  endtask

  task automatic test_unexpected_addr();
    load(0, 84, 7);
    arm(1, 80, 80, 0);
    exp_q.push_back(mk(1, 0, 2, 88, 7, 0));
    wr(88, 7);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL unexpected_addr: got %h expected %h", got, expv); end
    do_clear();
    // lo > hi: empty window, so 85 is not ignored
    arm(1, 90, 80, 0);
    exp_q.push_back(mk(1, 0, 2, 85, 0, 0));
    wr(85, 0);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL empty_window: got %h expected %h", got, expv); end
    do_clear();
  endtask

  task automatic test_timeout();
    load(0, 84, 7);
    load(1, 88, 3);
    arm(2, 80, 80, 10);
    exp_q.push_back(mk(1, 0, 3, 0, 0, 1));
    idle(2);
    wr(84, 7);
    wait_done(20);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL timeout: got %h expected %h", got, expv); end
    tests++;
    if (cycle_count !== 8'd10) begin fails++; $display("FAIL timeout_cycles: got %0d expected 10", cycle_count); end
    do_clear();
    arm(2, 80, 80, 10);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 2));
    idle(2);
    wr(84, 7);
    idle(6);
    wr(88, 3);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL timeout_race_pass: got %h expected %h", got, expv); end
    tests++;
    if (cycle_count !== 8'd10) begin fails++; $display("FAIL race_cycles: got %0d expected 10", cycle_count); end
    do_clear();
  endtask

  task automatic test_reset_clear_rerun();
    load(0, 84, 7);
    load(1, 88, 3);
    arm(2, 80, 80, 0);
    wr(84, 7);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv || cycle_count !== 8'd0) begin
      fails++; $display("FAIL async_reset: got %h cyc %0d expected %h cyc 0", got, cycle_count, expv);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    arm(2, 80, 80, 0);
    wr(99, 1);
    wait_done(5);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    do_clear();
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv || cycle_count !== 8'd0) begin
      fails++; $display("FAIL clear_from_fail: got %h cyc %0d expected %h cyc 0", got, cycle_count, expv);
    end
    arm(2, 80, 80, 0);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 2));
    wr(84, 7); wr(88, 3);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL rerun_retained_table: got %h expected %h", got, expv); end
    do_clear();
  endtask

  task automatic test_cfg_and_start_same_cycle();
    load(0, 84, 7);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 40; cfg_data = 1;
    cfg_count = 4'd1; scratch_lo = 80; scratch_hi = 80; timeout_limit = 0; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    exp_q.push_back(mk(1, 1, 0, 0, 0, 1));
    wr(40, 1);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL cfg_start_same_cycle: got %h expected %h", got, expv); end
    do_clear();
  endtask

  task automatic test_zero_count();
    arm(0, 80, 80, 0);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0));
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL zero_count_pass: got %h expected %h", got, expv); end
    do_clear();
  endtask

  task automatic test_saturate();
    load(0, 84, 7);
    arm(1, 80, 80, 0);
    idle(300);
    tests++;
    if (cycle_count !== 8'hFF) begin fails++; $display("FAIL cycle_saturate: got %0d expected 255", cycle_count); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL no_timeout_when_zero: done got %b expected 0", done); end
    do_clear();
  endtask

  task automatic test_out_of_order();
    load(0, 84, 7);
    load(1, 88, 3);
    arm(2, 80, 80, 0);
`ifdef MEMWRITE_CHECKER_UNORDERED_EN
    exp_q.push_back(mk(1, 1, 0, 0, 0, 2));
`else
    exp_q.push_back(mk(1, 0, 2, 88, 3, 0));
`endif
    wr(88, 3); wr(84, 7);
    wait_done(5);
    got = obs(); expv = exp_q.pop_front(); tests++;
    if (got !== expv) begin fails++; $display("FAIL out_of_order: got %h expected %h", got, expv); end
    do_clear();
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; start = 1'b0; clear = 1'b0; memwrite = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_count = '0;
    scratch_lo = '0; scratch_hi = '0; timeout_limit = '0; dataadr = '0; writedata = '0;
    test_reset();
    test_in_order_pass();
    test_data_mismatch();
    test_unexpected_addr();
    test_timeout();
    test_reset_clear_rerun();
    test_cfg_and_start_same_cycle();
    test_zero_count();
    test_saturate();
    test_out_of_order();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memwrite_checker.md
Name: memwrite_checker

Overview:
Synthesizable self-check monitor for multicycle/pipelined core benches and FPGA bring-up. It watches the core's data-memory write port and compares each write against a programmable table of expected (address, data) pairs. Writes inside a scratch window are ignored. It reports pass, fail cause, or timeout, with cycle and match counts. It replaces hard-wired "write 7 to 84" checks with a parametrised, multi-entry, multi-mode checker.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, write data width
DEPTH, 8, max expected-write entries (power of 2, >=2)
CNT_W, 32, width of cycle counter and timeout limit

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  write one table entry (accepted only in IDLE)
cfg_idx  in  log2(DEPTH)  table index
cfg_addr  in  ADDR_W  expected address
cfg_data  in  DATA_W  expected data
cfg_count  in  log2(DEPTH)+1  number of valid entries, sampled on start
scratch_lo  in  ADDR_W  ignore-window low bound (inclusive)
scratch_hi  in  ADDR_W  ignore-window high bound (inclusive)
timeout_limit  in  CNT_W  armed-cycle budget; 0 disables timeout
start  in  1  arm pulse (IDLE only)
clear  in  1  synchronous return to IDLE from any state
memwrite  in  1  core write strobe
dataadr  in  ADDR_W  core write address
writedata  in  DATA_W  core write data
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail_code  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout
fail_addr  out  ADDR_W  dataadr of the failing write (0 on timeout)
fail_data  out  DATA_W  writedata of the failing write (0 on timeout)
match_count  out  log2(DEPTH)+1  expected entries matched so far
cycle_count  out  CNT_W  cycles spent ARMED, saturating

Behaviour:
- Reset (reset=0, async): state IDLE. done, pass, fail_code, fail_addr, fail_data, match_count, cycle_count all 0. Table contents undefined.
- States: IDLE, ARMED, PASS, FAIL. PASS and FAIL are sticky until clear or reset.
- IDLE:
  - cfg_we writes table[cfg_idx].
  - start latches cfg_count, zeroes counters, goes to ARMED.
  - With cfg_count=0, start goes directly to PASS.
  - cfg_we and start in the same cycle: the write lands first; start sees the new entry.
- ARMED: cycle_count increments every cycle, saturating at all-ones. Each cycle with memwrite=1 is evaluated against entry E=table[match_count], in this priority:
  1. dataadr==E.addr and writedata==E.data: match_count+1. On reaching count, go to PASS in that same edge.
  2. dataadr==E.addr, data differs: FAIL, code 1.
  3. scratch_lo<=dataadr<=scratch_hi: ignored. The window is empty if lo>hi.
  4. Otherwise: FAIL, code 2.
  On FAIL, capture dataadr and writedata into fail_addr and fail_data.
- Timeout: if timeout_limit!=0 and cycle_count==timeout_limit-1 at an edge with no completing match, go to FAIL, code 3. A completing match in the same cycle wins and the result is PASS.
- memwrite is not evaluated in the start cycle, or in IDLE, PASS, or FAIL.
- cfg_we and start are ignored outside IDLE.
- clear has priority over everything except reset. It returns to IDLE and zeroes outputs; the table is kept.
- Latency: outputs are registered; done rises on the edge after the deciding write is sampled.
- Address comparisons are unsigned, full ADDR_W.

Optional Feature:
Macro MEMWRITE_CHECKER_UNORDERED_EN.
- Defined: expected entries may match in any order. A DEPTH-bit hit mask is cleared on start.
  - A write matches the lowest-index unhit entry with equal addr and data; that entry is marked hit and match_count increments.
  - If no entry matches and some unhit entry has an equal addr (data differs): code 1.
  - A write to an address whose entries are all already hit: code 2, unless it falls in the scratch window.
  - PASS when the popcount of the mask reaches count.
- Undefined: strict in-order checking as in Behaviour; no hit mask is synthesized.

Test Plan:
- table[0]=(84,7), count=1, scratch 80..80, limit 0; start; writes (80,5), (80,9), (84,7) -> PASS, done=1, pass=1, match_count=1, fail_code=0.
- Same config; writes (80,5), (84,6) -> FAIL, code 1, fail_addr=84, fail_data=6, match_count=0.
- Same config; write (88,7) -> FAIL, code 2, fail_addr=88.
- table (84,7),(88,3), count=2, limit 10; write (84,7) at armed cycle 2, then no writes -> FAIL, code 3 on the edge where cycle_count would reach 10; match_count=1. Also: (88,3) presented in the limit-1 cycle -> PASS.
- Apply reset=0 mid-ARMED after one match, then clear mid-FAIL -> all outputs 0, state IDLE. Re-start with the retained table -> PASS repeats.
- With UNORDERED_EN: table (84,7),(88,3), count 2; writes (88,3), (84,7) -> PASS. Same writes without the macro -> FAIL, code 1, fail_addr=88? No: code 2 (88 is not entry 0's addr and is outside scratch), fail_addr=88.
